// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: merges memory stalls, EX redirects and ID data
// hazards into PC/pipeline-register controls, with saturating perf counters and a hang detector.
module hazard_ctrl #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned FORWARDING = 1,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  logic             ex_valid,
  input  logic             br_en,
  input  logic             ex_jal,
  input  logic             ex_jalr,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             idex_mem_read,
  input  logic             idex_we,
  input  logic             exmem_we,
  input  logic             memwb_we,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic [REG_W-1:0] memwb_rd,
  output logic             pc_en,
  output logic [1:0]       pcmux_sel,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] hazard_bubbles,
  output logic             hang_err
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] SEL_PC4  = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_JALR = 2'd2;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMR_W-1:0] r_stall_timer;
  logic [TMR_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;
  logic [CNT_W-1:0] r_hazard_bubbles;
  logic             r_hang_err;

  logic w_mem_stall;
  logic w_redirect;
  logic w_data_haz;
  logic w_match_idex;
  logic w_match_exmem;
  logic w_match_memwb;

  // An ID source collides with a writer when it reads the same non-x0 register.
  function automatic logic src_match(input logic [REG_W-1:0] rd);
    return (rd != '0) &&
           ((id_use_rs1 && (id_rs1 == rd)) || (id_use_rs2 && (id_rs2 == rd)));
  endfunction

  assign w_mem_stall   = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
  assign w_redirect    = ex_valid & (br_en | ex_jal | ex_jalr);
  assign w_match_idex  = src_match(idex_rd);
  assign w_match_exmem = src_match(exmem_rd);
  assign w_match_memwb = src_match(memwb_rd);

  // With forwarding only a load in ID/EX can't be bypassed; without it any pending writer stalls.
  always_comb begin
    if (FORWARDING != 0) begin
      w_data_haz = idex_mem_read & w_match_idex;
    end else begin
      w_data_haz = (idex_we & w_match_idex) | (exmem_we & w_match_exmem) |
                   (memwb_we & w_match_memwb);
    end
  end

  // Pipeline controls, priority rst > mem_stall > redirect > data_haz > run.
  always_comb begin
    pc_en      = 1'b1;
    pcmux_sel  = SEL_PC4;
    IFID_en    = 1'b1;
    IDEX_en    = 1'b1;
    EXMEM_en   = 1'b1;
    MEMWB_en   = 1'b1;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_en    = 1'b0;
      EXMEM_en   = 1'b0;
      MEMWB_en   = 1'b0;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (w_mem_stall) begin
      pc_en    = 1'b0;
      IFID_en  = 1'b0;
      IDEX_en  = 1'b0;
      EXMEM_en = 1'b0;
      MEMWB_en = 1'b0;
    end else if (w_redirect) begin
      pcmux_sel  = ex_jalr ? SEL_JALR : SEL_ALU;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (w_data_haz) begin
      pc_en      = 1'b0;
      IFID_en    = 1'b0;
      IDEX_flush = 1'b1;
    end
  end

  // Stall FSM; the timer only runs while a memory stall is held.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = '0;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = STALL;
          w_timer_nxt = TMR_W'(1);
        end
      end
      STALL: begin
        if (w_mem_stall) begin
          w_timer_nxt = (r_stall_timer == TMR_W'(TIMEOUT)) ? r_stall_timer
                                                            : r_stall_timer + TMR_W'(1);
        end else begin
          w_state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_stall_timer <= '0;
      r_hang_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_stall_timer <= w_timer_nxt;
      if (w_mem_stall && (r_stall_timer == TMR_W'(TIMEOUT - 1))) begin
        r_hang_err <= 1'b1;
      end
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles   <= '0;
      r_flush_events   <= '0;
      r_hazard_bubbles <= '0;
    end else begin
      if (w_mem_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_redirect && !w_mem_stall && (r_flush_events != {CNT_W{1'b1}})) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
      if (w_data_haz && !w_mem_stall && !w_redirect &&
          (r_hazard_bubbles != {CNT_W{1'b1}})) begin
        r_hazard_bubbles <= r_hazard_bubbles + CNT_W'(1);
      end
    end
  end

  assign stall_cycles   = r_stall_cycles;
  assign flush_events   = r_flush_events;
  assign hazard_bubbles = r_hazard_bubbles;
  assign hang_err       = r_hang_err;

endmodule
